// File: rtl/bottling_ctrl_core.sv
// Pill-bottling station core: target entry, BCD pill/bottle counting, switch timing, fault and beeper control.
// Optional pause support is built when PAUSE_EN is defined.
module bottling_ctrl_core #(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2,
    parameter int TICK_DIV      = 1000,
    parameter int HOPPER_TO_S   = 5,
    parameter int SWITCH_S      = 2,
    parameter int CHIRP_CYC     = 1000
) (
    input  logic                       clk_1khz,
    input  logic                       switch_clr,
    input  logic                       i_btn_sel,
    input  logic                       i_btn_inc,
    input  logic                       i_btn_start,
    input  logic                       i_emergency_stop,
    input  logic                       i_hopper_pulse,
    input  logic                       i_conveyor_ok,
    output logic [2:0]                 o_state,
    output logic [2:0]                 o_cursor,
    output logic [4*PILL_DIGITS-1:0]   o_target_pills_bcd,
    output logic [4*BOTTLE_DIGITS-1:0] o_target_bottles_bcd,
    output logic [4*PILL_DIGITS-1:0]   o_now_pills_bcd,
    output logic [4*BOTTLE_DIGITS-1:0] o_now_bottles_bcd,
    output logic                       o_err_cause,
    output logic [1:0]                 o_beep_code,
    output logic                       o_chirp
);
    // state     | meaning
    // SETTING   | target entry via sel/inc, start validated
    // RUNNING   | counting pills, hopper timeout armed
    // SWITCHING | bottle change, hopper ignored
    // DONE      | all bottles filled
    // ERROR     | hopper starved (cause 0) or conveyor stopped (cause 1)
    // FATAL     | emergency stop
    // PAUSED    | run frozen (PAUSE_EN builds only)
    typedef enum logic [2:0] {
        S_SETTING = 3'd0, S_RUNNING = 3'd1, S_SWITCHING = 3'd2, S_DONE = 3'd3,
        S_ERROR = 3'd4, S_FATAL = 3'd5, S_PAUSED = 3'd6
    } state_t;

    localparam int PW    = 4 * PILL_DIGITS;
    localparam int BW    = 4 * BOTTLE_DIGITS;
    localparam int ND    = PILL_DIGITS + BOTTLE_DIGITS;
    localparam int HOP_T = HOPPER_TO_S * TICK_DIV;
    localparam int SW_T  = SWITCH_S * TICK_DIV;
    localparam int TMAX  = (HOP_T > SW_T) ? HOP_T : SW_T;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int CW    = $clog2(CHIRP_CYC + 1);
`ifdef PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [PW-1:0] pills_inc(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < PILL_DIGITS; i++) begin
            if (c) begin
                r[4*i +: 4] = digit_inc(v[4*i +: 4]);
                c = (v[4*i +: 4] >= 4'd9);
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bottles_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < BOTTLE_DIGITS; i++) begin
            if (c) begin
                r[4*i +: 4] = digit_inc(v[4*i +: 4]);
                c = (v[4*i +: 4] >= 4'd9);
            end
        end
        return r;
    endfunction

    state_t        r_state;
    logic [2:0]    r_cursor;
    logic [PW-1:0] r_tgt_p, r_now_p;
    logic [BW-1:0] r_tgt_b, r_now_b;
    logic          r_err_cause;
    logic [TW-1:0] r_hop_tmr, r_sw_tmr;
    logic [CW-1:0] r_chirp_cnt;
    logic          r_prev_sel, r_prev_inc, r_prev_start, r_prev_hop;

    logic          w_sel_e, w_inc_e, w_start_e, w_hop_e, w_any_btn;
    logic          w_start_blk, w_count, w_pill_full, w_bottle_full;
    logic [PW-1:0] w_pills_inc;
    logic [BW-1:0] w_bottles_inc;

    assign w_sel_e       = i_btn_sel & ~r_prev_sel;
    assign w_inc_e       = i_btn_inc & ~r_prev_inc;
    assign w_start_e     = i_btn_start & ~r_prev_start;
    assign w_hop_e       = i_hopper_pulse & ~r_prev_hop;
    assign w_any_btn     = w_sel_e | w_inc_e | w_start_e;
    assign w_pills_inc   = pills_inc(r_now_p);
    assign w_bottles_inc = bottles_inc(r_now_b);
    assign w_pill_full   = (w_pills_inc == r_tgt_p);
    assign w_bottle_full = (w_bottles_inc == r_tgt_b);
    // A start edge takes precedence over a pill in the states where start has a meaning.
    assign w_start_blk   = w_start_e & ((r_state == S_ERROR) | (PAUSE_ON & (r_state == S_RUNNING)));
    assign w_count       = w_hop_e & ~w_start_blk &
                           ((r_state == S_RUNNING) | ((r_state == S_ERROR) & ~r_err_cause));

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            r_state      <= S_SETTING;
            r_cursor     <= '0;
            r_tgt_p      <= '0;
            r_tgt_b      <= '0;
            r_now_p      <= '0;
            r_now_b      <= '0;
            r_err_cause  <= 1'b0;
            r_hop_tmr    <= '0;
            r_sw_tmr     <= '0;
            r_chirp_cnt  <= '0;
            r_prev_sel   <= 1'b1;
            r_prev_inc   <= 1'b1;
            r_prev_start <= 1'b1;
            r_prev_hop   <= 1'b1;
        end else begin
            r_prev_sel   <= i_btn_sel;
            r_prev_inc   <= i_btn_inc;
            r_prev_start <= i_btn_start;
            r_prev_hop   <= i_hopper_pulse;
            if (r_chirp_cnt != '0)
                r_chirp_cnt <= r_chirp_cnt - CW'(1);

            if (i_emergency_stop) begin
                r_state     <= S_FATAL;
                r_chirp_cnt <= '0;
            end else if (w_count) begin
                r_now_p <= w_pills_inc;
                if (w_pill_full) begin
                    r_now_b <= w_bottles_inc;
                    if (w_bottle_full) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state  <= S_SWITCHING;
                        r_sw_tmr <= TW'(SW_T);
                    end
                end else begin
                    r_state   <= S_RUNNING;
                    r_hop_tmr <= TW'(HOP_T);
                    if (r_state == S_ERROR)
                        r_chirp_cnt <= CW'(CHIRP_CYC);
                end
            end else begin
                case (r_state)
                    S_SETTING: begin
                        if (w_inc_e) begin
                            for (int d = 0; d < PILL_DIGITS; d++)
                                if (r_cursor == 3'(d))
                                    r_tgt_p[4*d +: 4] <= digit_inc(r_tgt_p[4*d +: 4]);
                            for (int d = 0; d < BOTTLE_DIGITS; d++)
                                if (r_cursor == 3'(PILL_DIGITS + d))
                                    r_tgt_b[4*d +: 4] <= digit_inc(r_tgt_b[4*d +: 4]);
                        end
                        if (w_sel_e)
                            r_cursor <= (r_cursor == 3'(ND - 1)) ? 3'd0 : r_cursor + 3'd1;
                        if (w_start_e && (r_tgt_p != '0) && (r_tgt_b != '0)) begin
                            r_state     <= S_RUNNING;
                            r_now_p     <= '0;
                            r_now_b     <= '0;
                            r_hop_tmr   <= TW'(HOP_T);
                            r_chirp_cnt <= CW'(CHIRP_CYC);
                        end
                    end
                    S_RUNNING: begin
`ifdef PAUSE_EN
                        if (w_start_e)
                            r_state <= S_PAUSED;
                        else
`endif
                        if (r_hop_tmr <= TW'(1)) begin
                            r_state     <= S_ERROR;
                            r_err_cause <= 1'b0;
                        end else begin
                            r_hop_tmr <= r_hop_tmr - TW'(1);
                        end
                    end
                    S_SWITCHING: begin
                        if (r_sw_tmr <= TW'(1)) begin
                            if (i_conveyor_ok) begin
                                r_state     <= S_RUNNING;
                                r_now_p     <= '0;
                                r_hop_tmr   <= TW'(HOP_T);
                                r_chirp_cnt <= CW'(CHIRP_CYC);
                            end else begin
                                r_state     <= S_ERROR;
                                r_err_cause <= 1'b1;
                            end
                        end else begin
                            r_sw_tmr <= r_sw_tmr - TW'(1);
                        end
                    end
                    S_ERROR: begin
                        if (w_start_e) begin
                            r_state <= S_SETTING;
                        end else if (r_err_cause && i_conveyor_ok) begin
                            r_state     <= S_RUNNING;
                            r_now_p     <= '0;
                            r_hop_tmr   <= TW'(HOP_T);
                            r_chirp_cnt <= CW'(CHIRP_CYC);
                        end
                    end
                    S_DONE, S_FATAL: begin
                        if (w_any_btn)
                            r_state <= S_SETTING;
                    end
                    S_PAUSED: begin
`ifdef PAUSE_EN
                        if (w_start_e) begin
                            r_state     <= S_RUNNING;
                            r_hop_tmr   <= TW'(HOP_T);
                            r_chirp_cnt <= CW'(CHIRP_CYC);
                        end
`else
                        r_state <= S_SETTING;
`endif
                    end
                    default: r_state <= S_SETTING;
                endcase
            end
        end
    end

    always_comb begin
        o_beep_code = 2'b00;
        case (r_state)
            S_DONE:  o_beep_code = 2'b01;
            S_ERROR: o_beep_code = 2'b10;
            S_FATAL: o_beep_code = 2'b11;
            default: o_beep_code = 2'b00;
        endcase
    end

    assign o_state              = r_state;
    assign o_cursor             = r_cursor;
    assign o_target_pills_bcd   = r_tgt_p;
    assign o_target_bottles_bcd = r_tgt_b;
    assign o_now_pills_bcd      = r_now_p;
    assign o_now_bottles_bcd    = r_now_b;
    assign o_err_cause          = r_err_cause;
    assign o_chirp              = (r_chirp_cnt != '0);

endmodule

// File: tb/tb_bottling_ctrl_core.sv
// Directed bench for bottling_ctrl_core with a 10-cycle second: setting, runs, timeouts, faults, stop and reset.
module tb_bottling_ctrl_core;
    logic clk_1khz = 1'b0;
    logic switch_clr = 1'b1;
    logic sel = 1'b0, inc = 1'b0, start = 1'b0, estop = 1'b0, hop = 1'b0, conv = 1'b1;
    logic [2:0]  st, cur;
    logic [11:0] tp, np;
    logic [7:0]  tbot, nb;
    logic        err, chirp;
    logic [1:0]  beep;
    int total = 0;
    int bad = 0;

    bottling_ctrl_core #(
        .PILL_DIGITS(3), .BOTTLE_DIGITS(2), .TICK_DIV(10),
        .HOPPER_TO_S(5), .SWITCH_S(2), .CHIRP_CYC(10)
    ) dut (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr),
        .i_btn_sel(sel), .i_btn_inc(inc), .i_btn_start(start),
        .i_emergency_stop(estop), .i_hopper_pulse(hop), .i_conveyor_ok(conv),
        .o_state(st), .o_cursor(cur),
        .o_target_pills_bcd(tp), .o_target_bottles_bcd(tbot),
        .o_now_pills_bcd(np), .o_now_bottles_bcd(nb),
        .o_err_cause(err), .o_beep_code(beep), .o_chirp(chirp)
    );

    always #5 clk_1khz = ~clk_1khz;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic do_reset();
        sel = 0; inc = 0; start = 0; estop = 0; hop = 0; conv = 1;
        switch_clr = 0;
        #2;
        switch_clr = 1;
        tick();
    endtask

    // which: 0 sel, 1 inc, 2 start
    task automatic press(input int which);
        if (which == 0) sel = 1; else if (which == 1) inc = 1; else start = 1;
        tick();
        sel = 0; inc = 0; start = 0;
        tick();
    endtask

    task automatic pulse();
        hop = 1;
        tick();
        hop = 0;
        tick();
    endtask

    task automatic set_targets(input logic [11:0] p, input logic [7:0] b);
        for (int d = 0; d < 5; d++) begin
            logic [3:0] v;
            if (d < 3) v = p[4*d +: 4];
            else       v = b[4*(d-3) +: 4];
            for (int k = 0; k < int'(v); k++) press(1);
            press(0);
        end
    endtask

    task automatic test_reset();
        sel = 1;
        #3 switch_clr = 0;
        #2;
        total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
        total++; if (cur !== 3'd0) begin bad++; $display("FAIL reset_cursor got=%0d exp=0", cur); end
        total++; if ({tp, tbot, np, nb} !== 40'h0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {tp, tbot, np, nb}); end
        total++; if ({err, chirp, beep} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {err, chirp, beep}); end
        switch_clr = 1;
        tick(); tick();
        total++; if (cur !== 3'd0) begin bad++; $display("FAIL held_btn_no_edge got=%0d exp=0", cur); end
        sel = 0; tick();
        sel = 1; tick();
        total++; if (cur !== 3'd1) begin bad++; $display("FAIL first_sel got=%0d exp=1", cur); end
        sel = 0; tick();
    endtask

    task automatic test_setting();
        do_reset();
        sel = 1; inc = 1; tick();
        total++; if (tp !== 12'h001) begin bad++; $display("FAIL sel_inc_digit got=%h exp=001", tp); end
        total++; if (cur !== 3'd1) begin bad++; $display("FAIL sel_inc_cursor got=%0d exp=1", cur); end
        sel = 0; inc = 0; tick();
        repeat (9) press(1);
        total++; if (tp !== 12'h091) begin bad++; $display("FAIL digit_nine got=%h exp=091", tp); end
        press(1);
        total++; if (tp !== 12'h001) begin bad++; $display("FAIL digit_wrap got=%h exp=001", tp); end
        repeat (4) press(0);
        total++; if (cur !== 3'd0) begin bad++; $display("FAIL cursor_wrap got=%0d exp=0", cur); end
    endtask

    task automatic test_normal();
        do_reset();
        set_targets(12'h002, 8'h02);
        total++; if ({tp, tbot, 5'(cur)} !== {12'h002, 8'h02, 5'd0}) begin bad++; $display("FAIL targets_entry got=%h/%h/%0d exp=002/02/0", tp, tbot, cur); end
        start = 1; tick();
        total++; if (st !== 3'd1 || chirp !== 1'b1) begin bad++; $display("FAIL start_run got=%0d/%b exp=1/1", st, chirp); end
        start = 0; tick();
        pulse(); pulse();
        total++; if (st !== 3'd2 || nb !== 8'h01 || np !== 12'h002) begin bad++; $display("FAIL to_switching got=%0d/%h/%h exp=2/01/002", st, nb, np); end
        pulse();
        total++; if (np !== 12'h002 || st !== 3'd2) begin bad++; $display("FAIL switch_ignores_hop got=%h/%0d exp=002/2", np, st); end
        repeat (16) tick();
        total++; if (st !== 3'd2) begin bad++; $display("FAIL switch_hold19 got=%0d exp=2", st); end
        tick();
        total++; if (st !== 3'd1 || np !== 12'h000 || chirp !== 1'b1) begin bad++; $display("FAIL switch_expiry got=%0d/%h/%b exp=1/000/1", st, np, chirp); end
        pulse(); pulse();
        total++; if (st !== 3'd3 || beep !== 2'b01 || nb !== 8'h02) begin bad++; $display("FAIL done got=%0d/%b/%h exp=3/01/02", st, beep, nb); end
        press(1);
        total++; if (st !== 3'd0 || tp !== 12'h002 || nb !== 8'h02) begin bad++; $display("FAIL done_exit got=%0d/%h/%h exp=0/002/02", st, tp, nb); end
    endtask

    task automatic test_start_zero();
        do_reset();
        set_targets(12'h000, 8'h05);
        press(2);
        total++; if (st !== 3'd0) begin bad++; $display("FAIL start_zero_pills got=%0d exp=0", st); end
        do_reset();
        set_targets(12'h001, 8'h00);
        press(2);
        total++; if (st !== 3'd0) begin bad++; $display("FAIL start_zero_bottles got=%0d exp=0", st); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        set_targets(12'h005, 8'h01);
        start = 1; tick();
        cnt = chirp ? 1 : 0;
        start = 0;
        for (int n = 1; n < 50; n++) begin
            tick();
            if (chirp) cnt++;
        end
        total++; if (cnt != 10) begin bad++; $display("FAIL chirp_len got=%0d exp=10", cnt); end
        total++; if (st !== 3'd1) begin bad++; $display("FAIL timeout_hold49 got=%0d exp=1", st); end
        tick();
        total++; if (st !== 3'd4 || err !== 1'b0 || beep !== 2'b10) begin bad++; $display("FAIL hopper_timeout got=%0d/%b/%b exp=4/0/10", st, err, beep); end
        hop = 1; tick();
        total++; if (st !== 3'd1 || np !== 12'h001 || chirp !== 1'b1) begin bad++; $display("FAIL error_pill_resume got=%0d/%h/%b exp=1/001/1", st, np, chirp); end
        hop = 0; tick();
        repeat (49) tick();
        total++; if (st !== 3'd4) begin bad++; $display("FAIL second_timeout got=%0d exp=4", st); end
        press(2);
        total++; if (st !== 3'd0) begin bad++; $display("FAIL error_abort got=%0d exp=0", st); end
    endtask

    task automatic test_conveyor();
        do_reset();
        set_targets(12'h001, 8'h02);
        press(2);
        hop = 1; tick();
        total++; if (st !== 3'd2 || nb !== 8'h01) begin bad++; $display("FAIL conv_switch got=%0d/%h exp=2/01", st, nb); end
        hop = 0; conv = 0;
        repeat (19) tick();
        total++; if (st !== 3'd2) begin bad++; $display("FAIL conv_hold19 got=%0d exp=2", st); end
        tick();
        total++; if (st !== 3'd4 || err !== 1'b1 || beep !== 2'b10) begin bad++; $display("FAIL conveyor_err got=%0d/%b/%b exp=4/1/10", st, err, beep); end
        tick();
        total++; if (st !== 3'd4) begin bad++; $display("FAIL conveyor_err_hold got=%0d exp=4", st); end
        conv = 1; tick();
        total++; if (st !== 3'd1 || np !== 12'h000) begin bad++; $display("FAIL conveyor_resume got=%0d/%h exp=1/000", st, np); end
    endtask

    task automatic test_carry();
        do_reset();
        set_targets(12'h100, 8'h01);
        press(2);
        for (int i = 1; i <= 100; i++) begin
            pulse();
            if (i == 9) begin
                total++; if (np !== 12'h009) begin bad++; $display("FAIL carry_9 got=%h exp=009", np); end
            end
            if (i == 10) begin
                total++; if (np !== 12'h010) begin bad++; $display("FAIL carry_10 got=%h exp=010", np); end
            end
            if (i == 99) begin
                total++; if (np !== 12'h099 || st !== 3'd1) begin bad++; $display("FAIL carry_99 got=%h/%0d exp=099/1", np, st); end
            end
        end
        total++; if (st !== 3'd3 || np !== 12'h100 || nb !== 8'h01) begin bad++; $display("FAIL carry_done got=%0d/%h/%h exp=3/100/01", st, np, nb); end
    endtask

    task automatic test_estop();
        do_reset();
        set_targets(12'h005, 8'h01);
        press(2);
        pulse();
        estop = 1; tick();
        total++; if (st !== 3'd5 || beep !== 2'b11 || chirp !== 1'b0) begin bad++; $display("FAIL estop got=%0d/%b/%b exp=5/11/0", st, beep, chirp); end
        sel = 1; tick();
        total++; if (st !== 3'd5) begin bad++; $display("FAIL estop_held_btn got=%0d exp=5", st); end
        sel = 0; tick();
        estop = 0; tick();
        total++; if (st !== 3'd5) begin bad++; $display("FAIL estop_release got=%0d exp=5", st); end
        sel = 1; tick();
        total++; if (st !== 3'd0 || np !== 12'h001) begin bad++; $display("FAIL fatal_exit got=%0d/%h exp=0/001", st, np); end
        sel = 0; tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_targets(12'h005, 8'h01);
        press(2);
        pulse(); pulse();
        #3 switch_clr = 0;
        #1;
        total++; if ({st, cur} !== 6'd0) begin bad++; $display("FAIL async_state got=%0d/%0d exp=0/0", st, cur); end
        total++; if ({tp, tbot, np, nb, err, chirp, beep} !== 44'h0) begin bad++; $display("FAIL async_outputs got=%h exp=0", {tp, tbot, np, nb, err, chirp, beep}); end
        switch_clr = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_setting();
        test_normal();
        test_start_zero();
        test_timeout();
        test_conveyor();
        test_carry();
        test_estop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
